// File: rtl/mult_div_unit.sv
// Iterative-latency HI/LO multiply/divide unit.
// Results are formed from latched operands and committed when the busy counter expires.
module mult_div_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_1  = CW'(1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);

    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;

    logic               sgn, a_neg, b_neg;
    logic [2*WIDTH-1:0] ext_a, ext_b, prod;
    logic [WIDTH-1:0]   ua, ub, ub_safe, uq, ur, quo, rem;
    logic [WIDTH-1:0]   res_hi, res_lo;

    // One shared datapath: op_q[0] selects unsigned, op_q[1] selects divide.
    always_comb begin
        sgn     = ~op_q[0];
        a_neg   = sgn & a_q[WIDTH-1];
        b_neg   = sgn & b_q[WIDTH-1];
        ext_a   = {{WIDTH{a_neg}}, a_q};
        ext_b   = {{WIDTH{b_neg}}, b_q};
        prod    = ext_a * ext_b;
        ua      = a_neg ? -a_q : a_q;
        ub      = b_neg ? -b_q : b_q;
        ub_safe = (ub == '0) ? ONE_W : ub;
        uq      = ua / ub_safe;
        ur      = ua % ub_safe;
        quo     = (a_neg ^ b_neg) ? -uq : uq;
        rem     = a_neg ? -ur : ur;
        if (!op_q[1]) begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end else if (b_q == '0) begin
            res_hi = a_q;
            res_lo = '1;
        end else if (sgn && a_q == MIN_NEG && b_q == '1) begin
            res_hi = '0;
            res_lo = a_q;
        end else begin
            res_hi = rem;
            res_lo = quo;
        end
    end

    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        a_d    = a_q;
        b_d    = b_q;
        op_d   = op_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (busy_q) begin
            if (flush) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end else if (cnt_q == CNT_1) begin
                hi_d   = res_hi;
                lo_d   = res_lo;
                busy_d = 1'b0;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q - CNT_1;
            end
        end else if (start && !flush) begin
            case (op)
                OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                    a_d    = A;
                    b_d    = B;
                    op_d   = op[1:0];
                    busy_d = 1'b1;
                    cnt_d  = op[1] ? DIV_N : MULT_N;
                end
                OP_MTHI: hi_d = A;
                OP_MTLO: lo_d = A;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            a_q    <= a_d;
            b_q    <= b_d;
            op_q   <= op_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO queued at issue,
// popped and compared when the unit goes idle.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A, B;
    logic        flush;
    logic        busy;
    logic [31:0] HI, LO;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] exp_q[$];
    logic [31:0] m_hi, m_lo;

    mult_div_unit #(
        .WIDTH(32),
        .MULT_CYCLES(5),
        .DIV_CYCLES(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .op(op),
        .A(A),
        .B(B),
        .flush(flush),
        .busy(busy),
        .HI(HI),
        .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] h,
                                          input logic [31:0] l);
        longint sp;
        logic [63:0] up;
        int q, r;
        case (o)
            3'd0: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                return sp;
            end
            3'd1: begin
                up = {32'h0, a} * {32'h0, b};
                return up;
            end
            3'd2: begin
                if (b == 0) return {a, 32'hffffffff};
                if (a == 32'h80000000 && b == 32'hffffffff) return {32'h0, a};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {32'(r), 32'(q)};
            end
            3'd3: begin
                if (b == 0) return {a, 32'hffffffff};
                return {a % b, a / b};
            end
            3'd4: return {a, l};
            3'd5: return {h, a};
            default: return {h, l};
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        step();
        start = 1'b0;
        A     = $urandom;
        B     = $urandom;
    endtask

    // flush_at>0 aborts in that busy cycle; poke re-issues start in busy cycle 2.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int flush_at, input bit poke);
        int n;
        int exp_n;
        logic [63:0] e;
        exp_n = (o <= 3'd1) ? 5 : (o <= 3'd3) ? 10 : 0;
        e = model(o, a, b, m_hi, m_lo);
        if (flush_at == 0) exp_q.push_back(e);
        issue(o, a, b);
        n = 0;
        while (busy && n < 64) begin
            chk({tag, "_hold"}, {HI, LO}, {m_hi, m_lo});
            n++;
            if (n == flush_at) flush = 1'b1;
            if (poke && n == 2) begin
                start = 1'b1;
                op    = 3'd1;
                A     = 32'h0000_0003;
                B     = 32'h0000_0007;
            end
            step();
            flush = 1'b0;
            start = 1'b0;
        end
        if (flush_at > 0) begin
            chk({tag, "_cyc"}, 64'(n), 64'(flush_at));
            chk({tag, "_noc"}, {HI, LO}, {m_hi, m_lo});
        end else begin
            chk({tag, "_cyc"}, 64'(n), 64'(exp_n));
            if (exp_q.size() == 0) begin
                chk({tag, "_sb"}, 64'(1), 64'(0));
            end else begin
                e = exp_q.pop_front();
                chk(tag, {HI, LO}, e);
                m_hi = e[63:32];
                m_lo = e[31:0];
            end
        end
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        clk   = 1'b0;
        reset = 1'b0;
        start = 1'b0;
        op    = 3'd0;
        A     = '0;
        B     = '0;
        flush = 1'b0;
        m_hi  = '0;
        m_lo  = '0;
        #12;
        chk("rst", {31'h0, busy, HI, LO}, 96'h0);
        reset = 1'b1;
        step();

        run_op("mult_neg", 3'd0, 32'hFFFFFFFE, 32'd3, 0, 0);
        run_op("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2, 0, 0);
        run_op("divu", 3'd3, 32'hFFFFFFF9, 32'd2, 0, 0);
        run_op("divu_z", 3'd3, 32'd5, 32'd0, 0, 0);
        run_op("div_z", 3'd2, 32'hFFFFFF00, 32'd0, 0, 0);
        run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 0, 0);
        run_op("mthi", 3'd4, 32'h00001234, 32'd0, 0, 0);
        run_op("mult_fl3", 3'd0, 32'd77, 32'd99, 3, 0);
        run_op("mult_fl5", 3'd0, 32'd11, 32'd13, 5, 0);
        run_op("div_fl1", 3'd2, 32'd100, 32'd7, 1, 0);
        run_op("div_poke", 3'd2, 32'd1000, 32'hFFFFFFFD, 0, 1);
        run_op("b2b_multu", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
        run_op("mtlo", 3'd5, 32'hCAFEF00D, 32'd0, 0, 0);

        start = 1'b1;
        flush = 1'b1;
        op    = 3'd4;
        A     = 32'hDEADBEEF;
        step();
        chk("sf_mthi", {31'h0, busy, HI, LO}, {31'h0, 1'b0, m_hi, m_lo});
        op = 3'd0;
        step();
        start = 1'b0;
        flush = 1'b0;
        step();
        chk("sf_mult", {31'h0, busy, HI, LO}, {31'h0, 1'b0, m_hi, m_lo});

        start = 1'b1;
        op    = 3'd6;
        A     = 32'h5555AAAA;
        step();
        op = 3'd7;
        step();
        start = 1'b0;
        step();
        chk("rsvd", {31'h0, busy, HI, LO}, {31'h0, 1'b0, m_hi, m_lo});

        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(0, 5));
            ra = $urandom;
            rb = $urandom;
            if (i % 6 == 1) rb = 32'd0;
            if (i % 6 == 3) rb = 32'($urandom_range(1, 9));
            if (i % 6 == 4) ra = 32'h80000000;
            run_op($sformatf("rnd%0d_op%0d", i, ro), ro, ra, rb, 0, 0);
        end

        exp_q.push_back(model(3'd2, 32'd12345, 32'd17, m_hi, m_lo));
        issue(3'd2, 32'd12345, 32'd17);
        step();
        step();
        #3;
        reset = 1'b0;
        #1;
        chk("rst_async", {31'h0, busy, HI, LO}, 96'h0);
        void'(exp_q.pop_back());
        m_hi = '0;
        m_lo = '0;
        #1;
        reset = 1'b1;
        run_op("post_rst_mtlo", 3'd5, 32'h0BADF00D, 32'd0, 0, 0);
        for (int i = 0; i < 12; i++) step();
        chk("no_late", {31'h0, busy, HI, LO}, {31'h0, 1'b0, m_hi, m_lo});
        chk("sb_empty", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
